rate_tick_counter: RTL
======================

RATE_TICK_COUNTER -- requirements
Module: rate_tick_counter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- DIV_W, 28, divider width.
- CNT_W, 4, output counter width.
- CNT_MAX, 15, counter terminal value; legal range 1..2^CNT_W-1.
- RATE0, 0, divider reload for rate_sel=0.
- RATE1, 49999999, reload for rate_sel=1.
- RATE2, 99999999, reload for rate_sel=2.
- RATE3, 199999999, reload for rate_sel=3.
- Every RATEk < 2^DIV_W.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clock, in, 1, sole clock; all state updates on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- run, in, 1, level; 1 = advance divider, 0 = hold.
- par_load, in, 1, synchronous load/restart.
- load_val, in, CNT_W, counter value applied on par_load.
- rate_sel, in, 2, selects RATE0..RATE3.
- up_dn, in, 1, 1 = count up, 0 = count down.
- tick, out, 1, registered one-cycle pulse per divider period.
- count, out, CNT_W, registered counter value.
- wrap, out, 1, registered one-cycle pulse on counter wrap.

Function
REQ-003 Internal registers SHALL be div (DIV_W bits) and sel_q (2 bits, last applied rate_sel).
REQ-004 Per-edge priority SHALL be par_load > rate change > run > hold.
REQ-005 par_load=1: div<=RATE[rate_sel]; sel_q<=rate_sel; count<=min(load_val,CNT_MAX); tick<=0; wrap<=0.
REQ-006 Rate change (par_load=0, rate_sel!=sel_q): div<=RATE[rate_sel]; sel_q<=rate_sel; tick<=0; wrap<=0; count held. Applies regardless of run.
REQ-007 run=0, no load or rate change: div and count held; tick<=0; wrap<=0.
REQ-008 run=1, div!=0: div<=div-1; tick<=0; wrap<=0; count held.
REQ-009 run=1, div==0: div<=RATE[sel_q]; tick<=1; count steps per REQ-010/011 on the same edge.
REQ-010 Up step (up_dn=1): count==CNT_MAX -> count<=0, wrap<=1; else count<=count+1, wrap<=0.
REQ-011 Down step (up_dn=0): count==0 -> count<=CNT_MAX, wrap<=1; else count<=count-1, wrap<=0.
REQ-012 With continuous run=1 and no load or rate change, tick SHALL assert exactly once every RATE[sel_q]+1 cycles; RATE=0 gives tick high every cycle.
REQ-013 wrap SHALL only assert in a cycle where tick is also 1.
REQ-014 Pause/resume: deasserting run for N cycles SHALL delay the next tick by exactly N cycles, with no tick lost or duplicated.
REQ-015 up_dn is sampled only on tick edges; a change takes effect on the next step.
REQ-016 A count above CNT_MAX is unreachable; out-of-range load_val SHALL clamp to CNT_MAX.
REQ-017 Arithmetic SHALL be unsigned, with explicit wrap per REQ-010/011 (no reliance on natural overflow when CNT_MAX<2^CNT_W-1).

Reset
REQ-018 reset_n=0 SHALL immediately, independent of clock, force div=0, sel_q=0, count=0, tick=0, wrap=0.
REQ-019 Reset asserted mid-period SHALL abandon the period; no tick or wrap SHALL be emitted during reset.
REQ-020 First edge after release SHALL obey REQ-004: rate_sel!=0 triggers a reload; rate_sel=0 with run=1 ticks immediately (div=0).

Verification
REQ-021 Bench SHALL override parameters to RATE0=0, RATE1=3, RATE2=7, RATE3=15, CNT_MAX=9, CNT_W=4.
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset, rate_sel=1, run=1, up_dn=1 -> after reload, tick every 4 cycles; count 0,1,...,9,0; wrap high with the 9->0 tick only.
- rate_sel=0, run=1 -> tick high every cycle; count increments each cycle.
- up_dn=0 from count=0 -> next tick gives count=9, wrap=1.
- rate_sel=2, run=1; drop run for 5 cycles mid-period -> tick interval 8+5=13 cycles, then back to 8.
- Mid-period rate_sel 2->1 -> next cycle tick=0, div=3; following ticks every 4 cycles; count unchanged by the switch.
- par_load=1, load_val=12, run=1 simultaneously with div==0 -> count=9, tick=0; also reset_n low mid-period -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rate_tick_counter.sv
// -----------------------------------------------------------------------------
// rate_tick_counter
//
// Programmable-rate tick generator driving a bounded up/down counter.
//
// A down-counting divider is reloaded from one of four compile-time rates.
// Every time it reaches zero while running, it emits a one-cycle tick and
// steps the output counter once. The counter wraps explicitly between 0 and
// CNT_MAX, and pulses `wrap` on the same cycle as the tick that caused it.
//
// Parameters
//   DIV_W    divider width
//   CNT_W    output counter width
//   CNT_MAX  counter terminal value, 1 .. 2**CNT_W-1
//   RATE0..3 divider reload values for rate_sel = 0..3, each < 2**DIV_W
//
// Ports
//   clock     in   1      sole clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   run       in   1      level: 1 = advance divider, 0 = hold
//   par_load  in   1      synchronous load / restart
//   load_val  in   CNT_W  counter value applied on par_load (clamped)
//   rate_sel  in   2      selects RATE0..RATE3
//   up_dn     in   1      1 = count up, 0 = count down
//   tick      out  1      registered one-cycle pulse per divider period
//   count     out  CNT_W  registered counter value
//   wrap      out  1      registered one-cycle pulse on counter wrap
// -----------------------------------------------------------------------------
module rate_tick_counter #(
    parameter int unsigned DIV_W   = 28,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned CNT_MAX = 15,
    parameter int unsigned RATE0   = 0,
    parameter int unsigned RATE1   = 49999999,
    parameter int unsigned RATE2   = 99999999,
    parameter int unsigned RATE3   = 199999999
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             par_load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [1:0]       rate_sel,
    input  logic             up_dn,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(CNT_MAX);

    // Per-edge operation. The order of the enumerators is the priority order.
    typedef enum logic [1:0] {
        OP_LOAD,   // par_load: restart divider and load counter
        OP_RATE,   // rate_sel changed: restart divider at the new rate
        OP_RUN,    // run: advance divider, tick when it reaches zero
        OP_HOLD    // nothing to do: freeze divider and counter
    } op_e;

    // Reload value for a given rate selection.
    function automatic logic [DIV_W-1:0] rate_of(input logic [1:0] sel);
        logic [DIV_W-1:0] r;
        case (sel)
            2'd0:    r = DIV_W'(RATE0);
            2'd1:    r = DIV_W'(RATE1);
            2'd2:    r = DIV_W'(RATE2);
            default: r = DIV_W'(RATE3);
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;     // cycles remaining before the next tick
    logic [1:0]       r_sel_q;   // rate selection the divider is running at
    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic             r_wrap;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    op_e              w_op;
    logic [DIV_W-1:0] w_rate_new;     // reload for the requested rate
    logic [DIV_W-1:0] w_rate_cur;     // reload for the rate already applied
    logic [CNT_W-1:0] w_load_clamped;
    logic             w_div_zero;
    logic [CNT_W-1:0] w_count_step;   // counter value after one step
    logic             w_step_wrap;    // that step crosses the 0 / CNT_MAX seam

    assign w_rate_new = rate_of(rate_sel);
    assign w_rate_cur = rate_of(r_sel_q);
    assign w_div_zero = (r_div == '0);

    // Any load above the terminal value is pulled down to it, so a count
    // beyond CNT_MAX can never be reached.
    assign w_load_clamped = (load_val > LP_CNT_MAX) ? LP_CNT_MAX : load_val;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path can leave it unassigned and infer a latch.
        w_op = OP_HOLD;
        if (par_load) begin
            w_op = OP_LOAD;
        end else if (rate_sel != r_sel_q) begin
            w_op = OP_RATE;
        end else if (run) begin
            w_op = OP_RUN;
        end
    end

    // The wrap is compared explicitly against CNT_MAX and 0 rather than left
    // to binary overflow, because CNT_MAX need not be 2**CNT_W-1.
    always_comb begin
        w_count_step = r_count;
        w_step_wrap  = 1'b0;
        if (up_dn) begin
            if (r_count == LP_CNT_MAX) begin
                w_count_step = '0;
                w_step_wrap  = 1'b1;
            end else begin
                w_count_step = r_count + 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                w_count_step = LP_CNT_MAX;
                w_step_wrap  = 1'b1;
            end else begin
                w_count_step = r_count - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // With div = 0 and sel_q = 0, the first running edge after release
            // ticks at once when rate 0 is selected. Any other rate reloads
            // first, because it differs from sel_q.
            r_div   <= '0;
            r_sel_q <= 2'd0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            // Pulses are low unless this edge produces one.
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (w_op)
                OP_LOAD: begin
                    r_div   <= w_rate_new;
                    r_sel_q <= rate_sel;
                    r_count <= w_load_clamped;
                end
                OP_RATE: begin
                    // Abandon the current period and start a full one at the
                    // new rate. The counter keeps its value.
                    r_div   <= w_rate_new;
                    r_sel_q <= rate_sel;
                end
                OP_RUN: begin
                    if (w_div_zero) begin
                        // The reload of RATE gives a period of RATE+1 edges.
                        // up_dn is consulted only here, on tick edges.
                        r_div   <= w_rate_cur;
                        r_tick  <= 1'b1;
                        r_count <= w_count_step;
                        r_wrap  <= w_step_wrap;
                    end else begin
                        r_div <= r_div - 1'b1;
                    end
                end
                OP_HOLD: begin
                    // The divider and counter are frozen. A pause of N edges
                    // therefore shifts the next tick by exactly N edges.
                end
            endcase
        end
    end

    assign tick  = r_tick;
    assign count = r_count;
    assign wrap  = r_wrap;

endmodule
